alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, registered, multi-cycle successor to the lab combinational ALU.
- Adds an iterative shift-add multiplier and a logical shift-left operation.
- Registers the result and the NZCV flags, and adds a valid/ready handshake on both input and output.
- Sits between the datapath register file and the writeback/flags register of the processor lab designs.

Parameters:
N, 8, operand/result width in bits; power of two, N >= 4.

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-high reset
in_valid  input  1  operands and Cntr are valid this cycle
in_ready  output  1  block can accept an operation
A  input  N  signed operand A
B  input  N  signed operand B
Cntr  input  3  operation select
out_valid  output  1  R and ALUFlags are valid
out_ready  input  1  consumer takes the result this cycle
R  output  N  registered signed result
ALUFlags  output  4  registered flags: [0] Z, [1] C, [2] N, [3] V

Behaviour:
- Clock and reset: single clock clk. Reset is asynchronous and active-high.
- Reset values:
  - state IDLE, in_ready=1, out_valid=0, R=0, ALUFlags=0.
  - Internal counter, multiplicand, multiplier and product registers are all 0.
- Operations, encoded on Cntr:
  - 000 ADD: R=A+B.
  - 001 SUB: R=A-B, computed as A+~B+1.
  - 010 AND: R=A&B.
  - 011 OR: R=A|B.
  - 100 NOT: R=~B.
  - 101 MOV: R=B.
  - 110 MUL: R = low N bits of unsigned A*B.
  - 111 LSL: R=A<<B[log2(N)-1:0]. Upper bits of B are ignored.
- Flags, captured together with R:
  - Z = (R==0). N = R[N-1].
  - ADD/SUB: C = carry out of the N-bit add (SUB: C=1 means no borrow). V = operands' effective signs equal and result sign differs.
  - MUL: C = 1 when the upper N bits of the 2N-bit unsigned product are nonzero. V=0.
  - LSL: C = last bit shifted out; C=0 when the shift amount is 0. V=0.
  - AND/OR/NOT/MOV: C=0, V=0.
- State machine, states IDLE, MUL, DONE:
  - IDLE: in_ready=1. On in_valid, latch A, B and Cntr.
    - Cntr=110: go to MUL with counter=0 and product=0.
    - Any other Cntr: compute R and flags into registers and go to DONE.
  - MUL: in_ready=0. Each cycle, if multiplier bit 0 = 1, add the multiplicand (2N-bit) into the product. Shift the multiplicand left and the multiplier right, and increment the counter. After exactly N iterations, load R and flags and go to DONE.
  - DONE: out_valid=1, in_ready=0. R and ALUFlags are held stable until the cycle in which out_ready=1, then go to IDLE.
    - There is no same-cycle accept of a new operation in DONE.
- Latency from the accept edge to out_valid:
  - Non-MUL operations: 1 cycle.
  - MUL: N+1 cycles.
  - Throughput is at most one operation per 2 cycles (non-MUL).
- in_valid while in_ready=0 is ignored; no operation is queued. Input changes during MUL/DONE do not affect R.
- R and ALUFlags keep their last value after the transfer back to IDLE. They are only valid while out_valid=1.
- Reset asserted mid-MUL or in DONE: all outputs go to reset values immediately, asynchronously. The in-flight operation is discarded.
- Width wrap: ADD/SUB/MUL results truncate to N bits. A shift amount of N-1 is the maximum.

Test Plan (N=8):
- ADD A=0x7F, B=0x01, out_ready=1 -> one cycle after accept: out_valid=1, R=0x80, ALUFlags=4'b1100 (V=1, N=1).
- SUB A=0x05, B=0x05 -> R=0x00, ALUFlags=4'b0011 (C=1, Z=1). Then SUB A=0x00, B=0x01 -> R=0xFF, ALUFlags=4'b0100.
- MUL A=0x10, B=0x11 -> out_valid exactly 9 cycles after accept, R=0x10, ALUFlags=4'b0010. Also MUL A=0x03, B=0x05 -> R=0x0F, ALUFlags=4'b0000.
- LSL A=0x81, B=0x01 -> R=0x02, ALUFlags=4'b0010. Then LSL A=0x81, B=0xF8 (shift amount 0) -> R=0x81, ALUFlags=4'b0100.
- Backpressure: hold out_ready=0 for 5 cycles after an OR 0xF0|0x0F result; pulse in_valid with new operands meanwhile -> R=0xFF and ALUFlags=4'b0100 stay stable, in_ready=0, and the new request is not executed. After out_ready=1: IDLE, in_ready=1.
- Assert reset on the 4th MUL cycle -> R=0, ALUFlags=0, out_valid=0 with no clock edge. After release, in_ready=1, and ADD 0x02+0x03 gives R=0x05, ALUFlags=4'b0000.

Source files
------------

// File: rtl/alu_seq_if.sv
// alu_seq_if: operand/result bundle for the sequential ALU.
//   Request side : in_valid, in_ready, A, B, Cntr
//   Response side: out_valid, out_ready, R, ALUFlags ([0] Z, [1] C, [2] N, [3] V)
//   master modport - the producer of operations / consumer of results
//   slave  modport - the ALU itself
interface alu_seq_if #(
    parameter int N = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [2:0]   Cntr;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] R;
    logic [3:0]   ALUFlags;

    modport master (
        output in_valid, A, B, Cntr, out_ready,
        input  in_ready, out_valid, R, ALUFlags
    );

    modport slave (
        input  in_valid, A, B, Cntr, out_ready,
        output in_ready, out_valid, R, ALUFlags
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered multi-cycle ALU with valid/ready handshakes.
//   clk   - rising-edge clock
//   reset - asynchronous, active-high reset
//   bus   - alu_seq_if.slave: operands A/B, opcode Cntr, result R, flags ALUFlags
// Single-cycle ops (ADD/SUB/AND/OR/NOT/MOV/LSL) finish on the accept edge;
// MUL runs an N-step shift-add loop. The result is held in DONE until taken.
module alu_seq #(
    parameter int N = 8
) (
    input  logic      clk,
    input  logic      reset,
    alu_seq_if.slave  bus
);
    localparam int SW = $clog2(N);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_NOT = 3'b100;
    localparam logic [2:0] OP_MOV = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_LSL = 3'b111;

    localparam logic [SW:0] CNT_LAST = (SW+1)'(N-1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t         state_r;
    logic           in_ready_r;
    logic           out_valid_r;
    logic [N-1:0]   r_r;
    logic [3:0]     flags_r;
    logic [SW:0]    cnt_r;
    logic [2*N-1:0] mcand_r;
    logic [N-1:0]   mplier_r;
    logic [2*N-1:0] prod_r;

    logic [N:0]     sum_s;
    logic [N:0]     shl_s;
    logic [N-1:0]   res_s;
    logic           c_s;
    logic           v_s;
    logic [2*N-1:0] prod_next_s;

    // Pack result-derived and op-specific flags as {V, N, C, Z}
    function automatic logic [3:0] make_flags(input logic [N-1:0] res,
                                              input logic c, input logic v);
        return {v, res[N-1], c, (res == {N{1'b0}})};
    endfunction

    // Single-cycle datapath, evaluated on the live operands in IDLE
    always_comb begin
        sum_s = {(N+1){1'b0}};
        // Bit N of the widened shift is the last bit shifted out (0 for amount 0)
        shl_s = {1'b0, bus.A} << bus.B[SW-1:0];
        res_s = {N{1'b0}};
        c_s   = 1'b0;
        v_s   = 1'b0;
        case (bus.Cntr)
            OP_ADD: begin
                sum_s = {1'b0, bus.A} + {1'b0, bus.B};
                res_s = sum_s[N-1:0];
                c_s   = sum_s[N];
                v_s   = (bus.A[N-1] == bus.B[N-1]) && (sum_s[N-1] != bus.A[N-1]);
            end
            OP_SUB: begin
                sum_s = {1'b0, bus.A} + {1'b0, ~bus.B} + {{N{1'b0}}, 1'b1};
                res_s = sum_s[N-1:0];
                c_s   = sum_s[N];
                v_s   = (bus.A[N-1] == ~bus.B[N-1]) && (sum_s[N-1] != bus.A[N-1]);
            end
            OP_AND: res_s = bus.A & bus.B;
            OP_OR:  res_s = bus.A | bus.B;
            OP_NOT: res_s = ~bus.B;
            OP_MOV: res_s = bus.B;
            OP_LSL: begin
                res_s = shl_s[N-1:0];
                c_s   = shl_s[N];
            end
            default: res_s = {N{1'b0}};
        endcase
    end

    // One shift-add step; the final step's sum is loaded straight into R
    always_comb begin
        if (mplier_r[0]) begin
            prod_next_s = prod_r + mcand_r;
        end else begin
            prod_next_s = prod_r;
        end
    end

    // Control FSM with registered handshake outputs, result and flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            r_r         <= {N{1'b0}};
            flags_r     <= 4'b0000;
            cnt_r       <= {(SW+1){1'b0}};
            mcand_r     <= {(2*N){1'b0}};
            mplier_r    <= {N{1'b0}};
            prod_r      <= {(2*N){1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        in_ready_r <= 1'b0;
                        if (bus.Cntr == OP_MUL) begin
                            mcand_r  <= {{N{1'b0}}, bus.A};
                            mplier_r <= bus.B;
                            prod_r   <= {(2*N){1'b0}};
                            cnt_r    <= {(SW+1){1'b0}};
                            state_r  <= ST_MUL;
                        end else begin
                            r_r         <= res_s;
                            flags_r     <= make_flags(res_s, c_s, v_s);
                            out_valid_r <= 1'b1;
                            state_r     <= ST_DONE;
                        end
                    end
                end
                ST_MUL: begin
                    prod_r   <= prod_next_s;
                    mcand_r  <= mcand_r << 1;
                    mplier_r <= mplier_r >> 1;
                    cnt_r    <= cnt_r + {{SW{1'b0}}, 1'b1};
                    if (cnt_r == CNT_LAST) begin
                        r_r         <= prod_next_s[N-1:0];
                        flags_r     <= make_flags(prod_next_s[N-1:0],
                                                  |prod_next_s[2*N-1:N], 1'b0);
                        out_valid_r <= 1'b1;
                        state_r     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.R         = r_r;
    assign bus.ALUFlags  = flags_r;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq (N=8).
// Inputs change on the falling edge; outputs are sampled 1 time unit after
// the rising edge.
module tb_alu_seq;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    alu_seq_if #(.N(8)) bus ();

    alu_seq #(.N(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) until the ALU is idle, on a falling edge
    task automatic wait_idle(input string tag);
        int guard = 0;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        check_val({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    endtask

    // Issue one operation, then scramble the inputs and measure latency
    task automatic run_op(input string tag, input logic [2:0] c,
                          input logic [7:0] a, input logic [7:0] b,
                          input int exp_lat, input logic [7:0] exp_r,
                          input logic [3:0] exp_f);
        int lat;
        wait_idle(tag);
        bus.A        = a;
        bus.B        = b;
        bus.Cntr     = c;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.A        = ~a;
        bus.B        = ~b;
        bus.Cntr     = c ^ 3'b001;
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_val({tag, "_lat"}, lat, exp_lat);
        check_val({tag, "_R"}, {24'd0, bus.R}, {24'd0, exp_r});
        check_val({tag, "_flags"}, {28'd0, bus.ALUFlags}, {28'd0, exp_f});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.A         = 8'h00;
        bus.B         = 8'h00;
        bus.Cntr      = 3'b000;
        #12;
        check_val("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
        check_val("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check_val("rst_R",         {24'd0, bus.R},         32'd0);
        check_val("rst_flags",     {28'd0, bus.ALUFlags},  32'd0);
        @(negedge clk);
        reset = 1'b0;

        // tag, op, A, B, latency, R, flags {V,N,C,Z}
        run_op("add_ovf",   3'b000, 8'h7F, 8'h01, 1, 8'h80, 4'b1100);
        run_op("add_carry", 3'b000, 8'hFF, 8'h01, 1, 8'h00, 4'b0011);
        run_op("sub_eq",    3'b001, 8'h05, 8'h05, 1, 8'h00, 4'b0011);
        run_op("sub_borrow",3'b001, 8'h00, 8'h01, 1, 8'hFF, 4'b0100);
        run_op("sub_ovf",   3'b001, 8'h80, 8'h01, 1, 8'h7F, 4'b1010);
        run_op("and",       3'b010, 8'hF0, 8'h3C, 1, 8'h30, 4'b0000);
        run_op("not",       3'b100, 8'h00, 8'h0F, 1, 8'hF0, 4'b0100);
        run_op("mov_zero",  3'b101, 8'hAA, 8'h00, 1, 8'h00, 4'b0001);
        run_op("mul_big",   3'b110, 8'h10, 8'h11, 9, 8'h10, 4'b0010);
        run_op("mul_small", 3'b110, 8'h03, 8'h05, 9, 8'h0F, 4'b0000);
        run_op("lsl1",      3'b111, 8'h81, 8'h01, 1, 8'h02, 4'b0010);
        run_op("lsl0",      3'b111, 8'h81, 8'hF8, 1, 8'h81, 4'b0100);
        run_op("lsl7",      3'b111, 8'h03, 8'h07, 1, 8'h80, 4'b0110);

        // Backpressure: result must hold and new requests must be ignored
        wait_idle("bp_pre");
        bus.out_ready = 1'b0;
        run_op("or_bp", 3'b011, 8'hF0, 8'h0F, 1, 8'hFF, 4'b0100);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.A        = 8'h01;
            bus.B        = 8'h01;
            bus.Cntr     = 3'b000;
            bus.in_valid = 1'b1;
            @(posedge clk);
            #1;
            check_val("bp_R",         {24'd0, bus.R},         32'h0000_00FF);
            check_val("bp_flags",     {28'd0, bus.ALUFlags},  32'd4);
            check_val("bp_in_ready",  {31'd0, bus.in_ready},  32'd0);
            check_val("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_val("bp_rel_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check_val("bp_rel_in_ready",  {31'd0, bus.in_ready},  32'd1);
        @(posedge clk);
        #1;
        check_val("bp_no_exec_valid", {31'd0, bus.out_valid}, 32'd0);
        check_val("bp_hold_R",        {24'd0, bus.R},         32'h0000_00FF);

        // Asynchronous reset on the 4th MUL cycle
        wait_idle("rst_mul");
        bus.A        = 8'h0F;
        bus.B        = 8'h0F;
        bus.Cntr     = 3'b110;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_val("amid_R",         {24'd0, bus.R},         32'd0);
        check_val("amid_flags",     {28'd0, bus.ALUFlags},  32'd0);
        check_val("amid_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check_val("amid_in_ready",  {31'd0, bus.in_ready},  32'd1);
        @(negedge clk);
        reset = 1'b0;
        run_op("add_after_rst", 3'b000, 8'h02, 8'h03, 1, 8'h05, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
